dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store initiator that sits between the pipeline's memory stage and the 256×32 data memory. It accepts one load or store request per handshake and converts it into whole-word data-memory accesses. Sub-word stores are performed as read-modify-write so that neighbouring bytes are preserved. Loaded bytes and halfwords are extracted and sign- or zero-extended before a single-cycle response is returned. All data-memory traffic uses word mode only; byte lanes are handled entirely inside this block.

## Interface
Parameters:
- ADDR_W, 32, request and data-memory address width

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the byte or halfword is taken from the low bits
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- resp_valid  out  1  response present
- resp_ready  in  1  response accepted
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or illegal funct3
- dmem_addr  out  32  word address to data memory; low 2 bits always 00
- dmem_wr_data  out  32  full word to write
- dmem_mem_wr  out  1  write strobe; memory commits on the negedge of the same cycle
- dmem_mem_rd  out  1  read enable; read is combinational
- dmem_mask  out  3  constant 3'b010
- dmem_rd_data  in  32  combinational read word

## Operation
- **States:** IDLE, RD, WR, RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch req_wr, req_addr, req_wdata and req_funct3.
  - Error check:
    - funct3 ∉ {000, 001, 010, 100, 101} → error.
    - Store with funct3 100 or 101 → error.
    - H with addr[0]=1 → misaligned error.
    - W with addr[1:0]≠0 → misaligned error.
  - Next state:
    - Error → RESP with resp_err=1. No dmem access is made.
    - Load → RD.
    - Word store → WR.
    - Byte or halfword store → RD.
- **RD:**
  - Drive dmem_mem_rd=1 and dmem_addr={addr[31:2],2'b00}.
  - Capture dmem_rd_data into an internal word register at the posedge.
  - Next state: load → RESP; sub-word store → WR.
- **WR:**
  - Drive dmem_mem_wr=1.
  - Word store: dmem_wr_data=wdata.
  - Byte store: the captured word with lane addr[1:0] replaced by wdata[7:0].
  - Halfword store: the captured word with half addr[1] replaced by wdata[15:0].
  - Next state → RESP.
- **Load extraction (computed from the captured word):**
  - B/BU: lane addr[1:0] (lane 0 = bits 7:0).
  - H/HU: half addr[1].
  - Sign extension for 000 and 001; zero extension for 100 and 101.
- **RESP:**
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready → IDLE.
  - A new request is not accepted in the same cycle as resp_ready (req_ready stays 0 in RESP).
- **Idle drive values:** when a strobe is not asserted, dmem_mem_rd, dmem_mem_wr, dmem_wr_data and dmem_addr are 0. Only one strobe is ever high at a time.

## Timing
- **Latency from the accept edge to resp_valid:**
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- **Throughput:**
  - Best case is one request per 3 cycles (word ops with resp_ready tied high): IDLE → op → RESP.
  - resp_ready low stalls in RESP indefinitely; no dmem activity occurs during the stall.
- **Reset:**
  - Values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, all dmem strobes 0, dmem_addr=0, dmem_wr_data=0, dmem_mask=3'b010, req_ready=1 from the first cycle after reset.
  - rst asserted in RD/WR/RESP aborts the operation. rst wins over every transition.
  - A WR cycle coinciding with rst: the strobe is driven combinationally from state, so a write whose cycle was already entered completes at that negedge. No further writes occur.
- **Input latching:** req_* are sampled only on the accept edge; later changes are ignored.
- dmem_rd_data is sampled only at the posedge ending the RD cycle.

## Test plan
- **Reset:** hold rst 2 cycles mid-RD → req_ready=1, resp_valid=0, dmem_mem_rd=0 the next cycle; memory is unchanged.
- **SW/LW:** SW 0xDEADBEEF @0x10, then LW @0x10 → dmem_mem_wr high exactly 1 cycle with dmem_addr=0x10; load resp_rdata=0xDEADBEEF, resp_err=0, latency 2.
- **Byte RMW:** with word @0x10=0xDEADBEEF, SB wdata=0x55 @0x12 → RD then WR with dmem_wr_data=0xDE55BEEF. Then:
  - LB @0x13 → 0xFFFFFFDE.
  - LBU @0x13 → 0x000000DE.
- **Halfword:** SH 0x8001 @0x16 over 0 → word @0x14 = 0x80010000. Then:
  - LH @0x16 → 0xFFFF8001.
  - LHU @0x16 → 0x00008001.
- **Errors:** each of the following → resp_err=1 after 1 cycle, resp_rdata=0, and no dmem strobes:
  - LW @0x11.
  - SH @0x13.
  - SB with funct3=100.
  - funct3=011.
- **Backpressure:** hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stay stable, req_ready=0, no dmem strobes; release → IDLE the next cycle.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the memory stage and a 256x32 data
// memory. Converts byte/halfword/word requests into whole-word accesses,
// doing read-modify-write for sub-word stores and extension for sub-word loads.
module dmem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wr_data,
    output logic              dmem_mem_wr,
    output logic              dmem_mem_rd,
    output logic [2:0]        dmem_mask,
    input  logic [31:0]       dmem_rd_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            state_q, state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic              err_q;
    logic [31:0]       word_q;
    logic              req_err;
    logic [31:0]       merged;
    logic [31:0]       load_data;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    // Data memory is always accessed in word mode.
    assign dmem_mask = 3'b010;

    // Classify the incoming request: illegal funct3, unsigned store, misalignment.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        req_err = 1'b0;
        case (req_funct3)
            F3_B:          req_err = 1'b0;
            F3_H:          req_err = req_addr[0];
            F3_W:          req_err = |req_addr[1:0];
            F3_BU, F3_HU:  req_err = req_wr;
            default:       req_err = 1'b1;
        endcase
    end

    // State register; reset overrides every transition.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request capture and read-word capture.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; the state register gates every use of them.
        if (state_q == IDLE && req_valid) begin
            wr_q     <= req_wr;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            err_q    <= req_err;
        end
        if (state_q == RD) word_q <= dmem_rd_data;
    end

    // Next-state logic and handshake/strobe outputs.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        dmem_mem_rd = 1'b0;
        dmem_mem_wr = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                          state_d = RESP;
                    else if (!req_wr || req_funct3 != F3_W) state_d = RD;
                    else                                  state_d = WR;
                end
            end
            RD: begin
                dmem_mem_rd = 1'b1;
                state_d     = wr_q ? WR : RESP;
            end
            WR: begin
                dmem_mem_wr = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Store word: replace the addressed byte/half lane of the captured word.
    always_comb begin
        merged = word_q;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load extraction with sign or zero extension.
    always_comb begin
        sel_byte  = word_q[{addr_q[1:0], 3'b000} +: 8];
        sel_half  = word_q[{addr_q[1], 4'b0000} +: 16];
        load_data = '0;
        case (funct3_q)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data = word_q;
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = '0;
        endcase
    end

    assign dmem_addr    = (dmem_mem_rd || dmem_mem_wr) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wr_data = dmem_mem_wr ? merged : '0;
    assign resp_rdata   = (state_q == RESP && !wr_q && !err_q) ? load_data : '0;
    assign resp_err     = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a 256x32 memory model
// (combinational read, write committed on the negedge of the strobe cycle).
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;
    logic        dmem_mem_wr, dmem_mem_rd;
    logic [2:0]  dmem_mask;

    logic [31:0] mem [256] = '{default: 32'h0};

    int          n_cmp = 0;
    int          n_err = 0;
    int          rd_total = 0;
    int          wr_total = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    dmem_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data),
        .dmem_mem_wr(dmem_mem_wr), .dmem_mem_rd(dmem_mem_rd),
        .dmem_mask(dmem_mask), .dmem_rd_data(dmem_rd_data)
    );

    always #5 clk = ~clk;

    assign dmem_rd_data = mem[dmem_addr[9:2]];

    always @(negedge clk) begin
        if (dmem_mem_wr) mem[dmem_addr[9:2]] <= dmem_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: counts accesses, checks exclusivity and idle drive values.
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_mem_rd) rd_total++;
            if (dmem_mem_wr) begin
                wr_total++;
                last_wr_addr = dmem_addr;
                last_wr_data = dmem_wr_data;
            end
            chk("one_strobe", {31'b0, dmem_mem_rd & dmem_mem_wr}, 32'h0);
            chk("mask", {29'b0, dmem_mask}, 32'h2);
            if (!dmem_mem_rd && !dmem_mem_wr) begin
                chk("idle_addr", dmem_addr, 32'h0);
                chk("idle_wdata", dmem_wr_data, 32'h0);
            end
        end
    end

    // One request from IDLE to back in IDLE, with optional response stall.
    task automatic do_op(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_rd, input int exp_wr,
                         input int hold);
        int lat;
        int rd0, wr0, rd1, wr1;
        rd0 = rd_total;
        wr0 = wr_total;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
        req_wr     = ~wr;
        req_funct3 = 3'b111;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_valid"}, {31'b0, resp_valid}, 32'h1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
        chk({tag, "_busy_ready"}, {31'b0, req_ready}, 32'h0);
        chk({tag, "_rd_cnt"}, rd_total - rd0, exp_rd);
        chk({tag, "_wr_cnt"}, wr_total - wr0, exp_wr);
        rd1 = rd_total;
        wr1 = wr_total;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'h1);
            chk({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
            chk({tag, "_hold_err"}, {31'b0, resp_err}, {31'b0, exp_err});
            chk({tag, "_hold_ready"}, {31'b0, req_ready}, 32'h0);
        end
        if (hold > 0) chk({tag, "_hold_strobes"}, (rd_total - rd1) + (wr_total - wr1), 0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, {31'b0, req_ready}, 32'h1);
        chk({tag, "_idle_valid"}, {31'b0, resp_valid}, 32'h0);
    endtask

    initial begin
        int wr0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = 3'b000;
        resp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_strobes", {30'b0, dmem_mem_rd, dmem_mem_wr}, 32'h0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_mask", {29'b0, dmem_mask}, 32'h2);

        // Word store then word load.
        do_op("sw", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 2, 0, 1, 0);
        chk("sw_addr", last_wr_addr, 32'h10);
        chk("sw_data", last_wr_data, 32'hDEAD_BEEF);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        do_op("lw", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, 0);

        // Byte read-modify-write and byte loads.
        do_op("sb", 1'b1, 32'h12, 32'h1234_5655, 3'b000, 32'h0, 1'b0, 3, 1, 1, 0);
        chk("sb_addr", last_wr_addr, 32'h10);
        chk("sb_data", last_wr_data, 32'hDE55_BEEF);
        do_op("lb13", 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FFDE, 1'b0, 2, 1, 0, 0);
        do_op("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h0000_00DE, 1'b0, 2, 1, 0, 0);
        do_op("lb11", 1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFF_FFBE, 1'b0, 2, 1, 0, 0);
        do_op("lbu12", 1'b0, 32'h12, 32'h0, 3'b100, 32'h0000_0055, 1'b0, 2, 1, 0, 0);

        // Halfword store over zero and halfword loads.
        do_op("sh", 1'b1, 32'h16, 32'h1234_8001, 3'b001, 32'h0, 1'b0, 3, 1, 1, 0);
        chk("sh_mem", mem[5], 32'h8001_0000);
        do_op("lh16", 1'b0, 32'h16, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0, 2, 1, 0, 0);
        do_op("lhu16", 1'b0, 32'h16, 32'h0, 3'b101, 32'h0000_8001, 1'b0, 2, 1, 0, 0);
        do_op("lh12", 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_DE55, 1'b0, 2, 1, 0, 0);
        do_op("lhu10", 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000_BEEF, 1'b0, 2, 1, 0, 0);

        // Error cases: one-cycle response, no memory traffic.
        do_op("err_lw11", 1'b0, 32'h11, 32'h0, 3'b010, 32'h0, 1'b1, 1, 0, 0, 0);
        do_op("err_sh13", 1'b1, 32'h13, 32'hFFFF_FFFF, 3'b001, 32'h0, 1'b1, 1, 0, 0, 0);
        do_op("err_sbu", 1'b1, 32'h10, 32'h0000_00AA, 3'b100, 32'h0, 1'b1, 1, 0, 0, 0);
        do_op("err_f3_011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1, 0, 0, 0);
        chk("err_mem_intact", mem[4], 32'hDE55_BEEF);

        // Backpressure: response stalled for 5 cycles.
        do_op("bp_lw", 1'b0, 32'h14, 32'h0, 3'b010, 32'h8001_0000, 1'b0, 2, 1, 0, 5);

        // Reset in the middle of a sub-word store's read cycle.
        wr0        = wr_total;
        req_valid  = 1'b1;
        req_wr     = 1'b1;
        req_addr   = 32'h10;
        req_wdata  = 32'h0000_00AA;
        req_funct3 = 3'b000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstrd_in_rd", {31'b0, dmem_mem_rd}, 32'h1);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rstrd_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rstrd_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rstrd_mem_rd", {31'b0, dmem_mem_rd}, 32'h0);
        chk("rstrd_no_write", wr_total - wr0, 0);
        chk("rstrd_mem", mem[4], 32'hDE55_BEEF);
        do_op("rstrd_lw", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDE55_BEEF, 1'b0, 2, 1, 0, 0);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
